// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one 8x8 multiplier among N_REQ requesters.
// One operation is in flight at a time: grant, start pulse, wait LATENCY
// cycles, then hold the product until the originating requester takes it.
module mul_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 1,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*16-1:0]  req_BA,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [15:0]          resp_prod,
  output logic [ID_W-1:0]      resp_id,
  output logic                 mul_start,
  output logic [15:0]          mul_ip_BA,
  input  logic [15:0]          mul_op_prod,
  input  logic                 mul_ready,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [15:0]         ba_q, ba_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [15:0]         prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         op_count_q, op_count_d;

  logic                grant_found_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [ID_W:0]       idx_s;
  logic [N_REQ-1:0]    req_ready_s;
  logic [N_REQ-1:0]    resp_valid_s;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    idx_s         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_s >= (ID_W+1)'(N_REQ)) begin
        idx_s = idx_s - (ID_W+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!grant_found_s && req_valid[idx_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_id_s    = idx_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state logic: grant in IDLE, pulse in START, count in WAIT, hold in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ba_d        = ba_q;
    id_d        = id_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    op_count_d  = op_count_q;
    req_ready_s = '0;
    case (state_q)
      S_IDLE: begin
        // Reset is folded in so no grant is offered while reset is held.
        if (reset && mul_ready && grant_found_s) begin
          req_ready_s[grant_id_s] = 1'b1;
        end else begin
          req_ready_s = '0;
        end
        if ((req_ready_s & req_valid) != '0) begin
          ba_d    = req_BA[{grant_id_s, 4'b0000} +: 16];
          id_d    = grant_id_s;
          state_d = S_START;
          if (grant_id_s == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_id_s + ID_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = mul_op_prod;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready[id_q]) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One-hot response valid for the requester being served.
  always_comb begin
    resp_valid_s = '0;
    if (state_q == S_RESP) begin
      resp_valid_s[id_q] = 1'b1;
    end else begin
      resp_valid_s = '0;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ba_q       <= '0;
      id_q       <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ba_q       <= ba_d;
      id_q       <= id_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_s;
  assign resp_prod  = prod_q;
  assign resp_id    = id_q;
  assign mul_start  = (state_q == S_START);
  assign mul_ip_BA  = ba_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: two instances (LATENCY 1 and 3) checked every cycle
// against a timeline model, plus directed scenarios with literal expectations.
module tb_mul_rr_sched;

  localparam int N    = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rv [2];
  logic [3:0]  rr [2];
  logic [63:0] ba [2];
  logic        mr [2];
  logic [3:0]  rq_o [2];
  logic [3:0]  vo [2];
  logic [15:0] prod_o [2];
  logic [1:0]  id_o [2];
  logic        ms_o [2];
  logic [15:0] mba [2];
  logic [15:0] mprod [2];
  logic        busy_o [2];
  logic [15:0] cnt_o [2];

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b1;
  bit preload [2];

  // model state: time since acceptance drives everything
  bit          m_busy [2];
  int          m_age [2];
  int          m_id [2];
  int          m_ptr [2];
  logic [15:0] m_ba [2];
  logic [15:0] m_prod [2];
  logic [15:0] m_count [2];

  // bench multiplier: product valid only exactly LATENCY cycles after start
  int msc [2];

  always #5 clk = ~clk;

  mul_rr_sched #(.N_REQ(4), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rq_o[0]), .req_BA(ba[0]),
    .resp_valid(vo[0]), .resp_ready(rr[0]), .resp_prod(prod_o[0]), .resp_id(id_o[0]),
    .mul_start(ms_o[0]), .mul_ip_BA(mba[0]), .mul_op_prod(mprod[0]), .mul_ready(mr[0]),
    .busy(busy_o[0]), .op_count(cnt_o[0])
  );

  mul_rr_sched #(.N_REQ(4), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rq_o[1]), .req_BA(ba[1]),
    .resp_valid(vo[1]), .resp_ready(rr[1]), .resp_prod(prod_o[1]), .resp_id(id_o[1]),
    .mul_start(ms_o[1]), .mul_ip_BA(mba[1]), .mul_op_prod(mprod[1]), .mul_ready(mr[1]),
    .busy(busy_o[1]), .op_count(cnt_o[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [3:0] v);
    for (int j = 0; j < N; j++) begin
      if (v[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // multiplier latency counter per instance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) msc[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ms_o[k]) msc[k] <= 1;
        else if (msc[k] != 0 && msc[k] < 100) msc[k] <= msc[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mprod[k] = 16'h5A5A;
      if (msc[k] == lat_of(k)) mprod[k] = {8'h00, mba[k][15:8]} * {8'h00, mba[k][7:0]};
    end
  end

  // reference model advanced on each clock
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_age[k] <= 0; m_id[k] <= 0; m_ptr[k] <= 0;
        m_ba[k] <= 16'h0000; m_prod[k] <= 16'h0000; m_count[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (preload[k]) m_count[k] <= 16'hFFFF;
        if (!m_busy[k]) begin
          if (mr[k] && rr_pick(m_ptr[k], rv[k]) >= 0) begin
            m_busy[k] <= 1'b1;
            m_age[k]  <= 1;
            m_id[k]   <= rr_pick(m_ptr[k], rv[k]);
            m_ba[k]   <= ba[k][rr_pick(m_ptr[k], rv[k]) * 16 +: 16];
            m_ptr[k]  <= (rr_pick(m_ptr[k], rv[k]) + 1) % N;
          end
        end else begin
          if (m_age[k] == 1 + lat_of(k))
            m_prod[k] <= {8'h00, m_ba[k][15:8]} * {8'h00, m_ba[k][7:0]};
          if (m_age[k] >= 2 + lat_of(k)) begin
            if (rr[k][m_id[k]]) begin
              m_busy[k]  <= 1'b0;
              m_count[k] <= m_count[k] + 16'd1;
            end
          end else begin
            m_age[k] <= m_age[k] + 1;
          end
        end
      end
    end
  end

  // per-cycle comparison of both instances against the model
  initial begin
    int pk;
    logic [3:0] e_rq;
    logic [3:0] e_rv;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          pk   = rr_pick(m_ptr[k], rv[k]);
          e_rq = (reset && !m_busy[k] && mr[k] && pk >= 0) ? (4'b0001 << pk) : 4'b0000;
          e_rv = (m_busy[k] && m_age[k] >= 2 + lat_of(k)) ? (4'b0001 << m_id[k]) : 4'b0000;
          chk($sformatf("k%0d req_ready", k), {28'd0, rq_o[k]}, {28'd0, e_rq});
          chk($sformatf("k%0d resp_valid", k), {28'd0, vo[k]}, {28'd0, e_rv});
          chk($sformatf("k%0d mul_start", k), {31'd0, ms_o[k]},
              {31'd0, (m_busy[k] && m_age[k] == 1)});
          chk($sformatf("k%0d busy", k), {31'd0, busy_o[k]}, {31'd0, m_busy[k]});
          chk($sformatf("k%0d mul_ip_BA", k), {16'd0, mba[k]}, {16'd0, m_ba[k]});
          chk($sformatf("k%0d resp_prod", k), {16'd0, prod_o[k]}, {16'd0, m_prod[k]});
          chk($sformatf("k%0d resp_id", k), {30'd0, id_o[k]}, m_id[k]);
          chk($sformatf("k%0d op_count", k), {16'd0, cnt_o[k]}, {16'd0, m_count[k]});
        end
      end
    end
  end

  task automatic wait_accept(input int k, output int who);
    who = -1;
    for (int c = 0; c < 50 && who < 0; c++) begin
      #1;
      if ((rq_o[k] & rv[k]) != 4'b0000) begin
        for (int j = 0; j < N; j++) if (rq_o[k][j]) who = j;
      end
      @(posedge clk);
      #1;
    end
    if (who < 0) begin
      n_total++;
      $display("FAIL accept_timeout k%0d: no grant within 50 cycles, required a grant", k);
    end
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while (busy_o[k] && c < 60) begin
      tick();
      c++;
    end
    if (busy_o[k]) begin
      n_total++;
      $display("FAIL idle_timeout k%0d: busy still 1 after 60 cycles, required 0", k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int exp_order [8];
    exp_order = '{0, 1, 2, 3, 0, 1, 3, 1};
    for (int k = 0; k < 2; k++) begin
      rv[k] = 4'b0000; rr[k] = 4'b0000; ba[k] = 64'd0; mr[k] = 1'b1; preload[k] = 1'b0;
    end

    // reset: outputs zero, no grant even with requests pending
    rv[0] = 4'b1111;
    repeat (3) @(posedge clk);
    #2;
    chk("rst req_ready", {28'd0, rq_o[0]}, 32'h0);
    chk("rst busy", {31'd0, busy_o[0]}, 32'h0);
    chk("rst op_count", {16'd0, cnt_o[0]}, 32'h0);
    tick();
    rv[0] = 4'b0000;
    reset = 1'b1;

    // single op from requester 2
    rr[0] = 4'b1111;
    ba[0][47:32] = 16'h0503;
    rv[0] = 4'b0100;
    wait_accept(0, who);
    rv[0] = 4'b0000;
    chk("t1 grant", who, 32'd2);
    #1 chk("t1 mul_start T+1", {31'd0, ms_o[0]}, 32'h1);
    tick();
    #1 chk("t1 resp_valid T+2", {28'd0, vo[0]}, 32'h0);
    tick();
    #1;
    chk("t1 resp_valid T+3", {28'd0, vo[0]}, 32'h4);
    chk("t1 resp_prod", {16'd0, prod_o[0]}, 32'h000F);
    chk("t1 resp_id", {30'd0, id_o[0]}, 32'd2);
    tick();
    chk("t1 op_count", {16'd0, cnt_o[0]}, 32'd1);
    chk("t1 idle", {31'd0, busy_o[0]}, 32'h0);

    // max operands, consumer stalls for 5 cycles
    rr[0] = 4'b0000;
    ba[0][15:0] = 16'hFFFF;
    rv[0] = 4'b0001;
    wait_accept(0, who);
    rv[0] = 4'b0010;
    tick();
    tick();
    repeat (5) begin
      #1;
      chk("t2 resp_valid hold", {28'd0, vo[0]}, 32'h1);
      chk("t2 resp_prod hold", {16'd0, prod_o[0]}, 32'hFE01);
      chk("t2 req_ready low", {28'd0, rq_o[0]}, 32'h0);
      tick();
    end
    rv[0] = 4'b0000;
    rr[0] = 4'b1111;
    tick();
    chk("t2 back to idle", {31'd0, busy_o[0]}, 32'h0);
    chk("t2 op_count", {16'd0, cnt_o[0]}, 32'd2);

    // round robin from pointer 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ba[0] = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
    rv[0] = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      if (g == 5) rv[0] = 4'b1010;
      wait_accept(0, who);
      chk($sformatf("t3 grant order %0d", g), who, exp_order[g]);
    end
    rv[0] = 4'b0000;
    wait_idle(0);

    // multiplier not ready
    mr[0] = 1'b0;
    ba[0][15:0] = 16'h0C0B;
    rv[0] = 4'b0001;
    repeat (3) begin
      #1;
      chk("t4 req_ready held", {28'd0, rq_o[0]}, 32'h0);
      chk("t4 no mul_start", {31'd0, ms_o[0]}, 32'h0);
      tick();
    end
    mr[0] = 1'b1;
    #1 chk("t4 req_ready same cycle", {28'd0, rq_o[0]}, 32'h1);
    wait_accept(0, who);
    rv[0] = 4'b0000;
    wait_idle(0);

    // reset during WAIT on the LATENCY=3 instance
    rr[1] = 4'b1111;
    ba[1][15:0] = 16'h0203;
    rv[1] = 4'b0001;
    wait_accept(1, who);
    rv[1] = 4'b0000;
    tick();
    #1 chk("t5 in wait busy", {31'd0, busy_o[1]}, 32'h1);
    reset = 1'b0;
    #1;
    chk("t5 rst busy", {31'd0, busy_o[1]}, 32'h0);
    chk("t5 rst mul_start", {31'd0, ms_o[1]}, 32'h0);
    chk("t5 rst mul_ip_BA", {16'd0, mba[1]}, 32'h0);
    chk("t5 rst resp_valid", {28'd0, vo[1]}, 32'h0);
    chk("t5 rst resp_prod", {16'd0, prod_o[1]}, 32'h0);
    chk("t5 rst resp_id", {30'd0, id_o[1]}, 32'h0);
    chk("t5 rst op_count", {16'd0, cnt_o[1]}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    repeat (6) begin
      #1 chk("t5 no stale resp", {28'd0, vo[1]}, 32'h0);
      tick();
    end
    ba[1] = {16'h0000, 16'h0909, 16'h0000, 16'h0406};
    rv[1] = 4'b0101;
    wait_accept(1, who);
    rv[1] = 4'b0000;
    chk("t5 pointer reset grant", who, 32'd0);
    wait_idle(1);
    chk("t5 resp_prod", {16'd0, prod_o[1]}, 32'h0018);
    chk("t5 op_count", {16'd0, cnt_o[1]}, 32'd1);

    // op_count wrap
    chk_en = 1'b0;
    force u_dut0.op_count_q = 16'hFFFF;
    preload[0] = 1'b1;
    tick();
    release u_dut0.op_count_q;
    preload[0] = 1'b0;
    chk_en = 1'b1;
    chk("t6 preload", {16'd0, cnt_o[0]}, 32'hFFFF);
    rr[0] = 4'b1111;
    ba[0][15:0] = 16'h0202;
    rv[0] = 4'b0001;
    wait_accept(0, who);
    rv[0] = 4'b0000;
    wait_idle(0);
    chk("t6 op_count wrap", {16'd0, cnt_o[0]}, 32'h0000);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
